// File: rtl/tinyqv_pkg.sv
// TinyQV interrupt controller shared definitions.
// CSR select/op encodings and nibble update helper.
package tinyqv_pkg;

   localparam logic [1:0] SEL_MIE  = 2'b00;
   localparam logic [1:0] SEL_MIP  = 2'b01;
   localparam logic [1:0] SEL_MODE = 2'b10;
   localparam logic [1:0] SEL_NONE = 2'b11;

   localparam logic [1:0] OP_NONE  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_SET   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   function automatic logic [3:0] apply_op(
      input logic [1:0] op,
      input logic [3:0] cur,
      input logic [3:0] wd
   );
      logic [3:0] r;
      unique case (op)
         OP_WRITE: r = wd;
         OP_SET:   r = cur | wd;
         OP_CLEAR: r = cur & ~wd;
         default:  r = cur;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/tinyqv_irq_sync.sv
// TinyQV per-line interrupt synchroniser.
// STAGES-deep sync chain plus one flop for rise detection.
module tinyqv_irq_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic irq,
   output logic synced,
   output logic rise
);

   logic [STAGES-1:0] chain;
   logic              last;

   // Shift the raw line through the chain, then keep last value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= '0;
         last  <= 1'b0;
      end else begin
         chain[0] <= irq;
         for (int i = 1; i < STAGES; i++)
            chain[i] <= chain[i-1];
         last <= chain[STAGES-1];
      end
   end

   assign synced = chain[STAGES-1];
   assign rise   = synced & ~last;

endmodule

// File: rtl/tinyqv_intc.sv
// TinyQV interrupt controller.
// Nibble-serial CSR access to mie/mip/mode, fixed priority.
import tinyqv_pkg::*;

module tinyqv_intc #(
   parameter int NUM_IRQ     = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2:0]         counter,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic [1:0]         csr_sel,
   input  logic [1:0]         csr_op,
   input  logic [3:0]         csr_wdata,
   output logic [3:0]         csr_rdata,
   input  logic               global_mie,
   input  logic               irq_ack,
   output logic               interrupt_pending,
   output logic [4:0]         irq_cause
);

   localparam logic [31:0] VALID =
      32'((64'd1 << NUM_IRQ) - 64'd1);

   logic [NUM_IRQ-1:0] synced;
   logic [NUM_IRQ-1:0] rise;
   logic [31:0] synced32, rise32;
   logic [31:0] mie, mode, pend;
   logic [31:0] mie_n, mode_n, pend_n;
   logic [31:0] eff, active;
   logic [3:0]  nib;
   logic [4:0]  base;

   for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
      tinyqv_irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
         .clk    (clk),
         .rst    (rst),
         .irq    (irq_in[g]),
         .synced (synced[g]),
         .rise   (rise[g])
      );
   end

   assign synced32 = 32'(synced);
   assign rise32   = 32'(rise);
   assign base     = {counter, 2'b00};

   // Level lines report live level, edge lines their latch
   assign eff    = (pend & mode) | (synced32 & ~mode);
   assign active = eff & mie;

   // CSR nibble update, edge-mode ack, then edge set wins
   always_comb begin
      mie_n  = mie;
      mode_n = mode;
      pend_n = pend;
      nib    = apply_op(csr_op, pend[base +: 4], csr_wdata);
      unique case (csr_sel)
         SEL_MIE:
            mie_n[base +: 4] =
               apply_op(csr_op, mie[base +: 4], csr_wdata);
         SEL_MODE:
            mode_n[base +: 4] =
               apply_op(csr_op, mode[base +: 4], csr_wdata);
         SEL_MIP:
            pend_n[base +: 4] =
               (nib & mode[base +: 4]) |
               (pend[base +: 4] & ~mode[base +: 4]);
         default: ;
      endcase
      if (irq_ack && mode[irq_cause])
         pend_n[irq_cause] = 1'b0;
      pend_n = pend_n | (rise32 & mode);
      mie_n  = mie_n & VALID;
      mode_n = mode_n & VALID;
      pend_n = pend_n & VALID;
   end

   // Register state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mie  <= '0;
         mode <= '0;
         pend <= '0;
      end else begin
         mie  <= mie_n;
         mode <= mode_n;
         pend <= pend_n;
      end
   end

   // Lowest active index wins
   always_comb begin
      irq_cause = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--)
         if (active[i])
            irq_cause = 5'(i);
   end

   assign interrupt_pending = global_mie & (|active);

   // Read mux for the nibble selected by counter
   always_comb begin
      csr_rdata = '0;
      unique case (csr_sel)
         SEL_MIE:  csr_rdata = mie[base +: 4];
         SEL_MIP:  csr_rdata = eff[base +: 4];
         SEL_MODE: csr_rdata = mode[base +: 4];
         default:  csr_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_tinyqv_intc.sv
// TinyQV interrupt controller bench.
// Directed vectors, NUM_IRQ=16 and NUM_IRQ=5 instances.
import tinyqv_pkg::*;

module tb_tinyqv_intc;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  counter;
   logic [15:0] irq_in = '0;
   logic [1:0]  csr_sel = SEL_NONE;
   logic [1:0]  csr_op = OP_NONE;
   logic [3:0]  csr_wdata = '0;
   logic        global_mie = 1'b0;
   logic        irq_ack = 1'b0;
   logic [3:0]  csr_rdata, csr_rdata5;
   logic        pend_o, pend5_o;
   logic [4:0]  cause, cause5;
   logic [31:0] rd, rd5;

   int n_chk = 0;
   int n_fail = 0;

   tinyqv_intc #(.NUM_IRQ(16), .SYNC_STAGES(2)) dut (
      .clk               (clk),
      .rst               (rst),
      .counter           (counter),
      .irq_in            (irq_in),
      .csr_sel           (csr_sel),
      .csr_op            (csr_op),
      .csr_wdata         (csr_wdata),
      .csr_rdata         (csr_rdata),
      .global_mie        (global_mie),
      .irq_ack           (irq_ack),
      .interrupt_pending (pend_o),
      .irq_cause         (cause)
   );

   tinyqv_intc #(.NUM_IRQ(5), .SYNC_STAGES(2)) dut5 (
      .clk               (clk),
      .rst               (rst),
      .counter           (counter),
      .irq_in            (irq_in[4:0]),
      .csr_sel           (csr_sel),
      .csr_op            (csr_op),
      .csr_wdata         (csr_wdata),
      .csr_rdata         (csr_rdata5),
      .global_mie        (global_mie),
      .irq_ack           (irq_ack),
      .interrupt_pending (pend5_o),
      .irq_cause         (cause5)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst)
      if (rst) counter <= '0;
      else     counter <= counter + 3'd1;

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic wait_cnt(input logic [2:0] c);
      @(negedge clk);
      for (int i = 0; i < 8 && counter != c; i++)
         @(negedge clk);
   endtask

   task automatic xfer(
      input  logic [1:0]  sel,
      input  logic [1:0]  op,
      input  logic [31:0] wd,
      output logic [31:0] r,
      output logic [31:0] r5
   );
      wait_cnt(3'd0);
      r = '0;
      r5 = '0;
      for (int k = 0; k < 8; k++) begin
         csr_sel   = sel;
         csr_op    = op;
         csr_wdata = wd[4*k +: 4];
         #1;
         r[4*k +: 4]  = csr_rdata;
         r5[4*k +: 4] = csr_rdata5;
         @(negedge clk);
      end
      csr_sel = SEL_NONE;
      csr_op  = OP_NONE;
   endtask

   task automatic ack_pulse();
      irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0;
   endtask

   initial begin
      #1 rst = 1'b1;
      #1;
      chk("rst_pend", 32'(pend_o), 0);
      chk("rst_cause", 32'(cause), 0);
      chk("rst_rdata", 32'(csr_rdata), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      xfer(SEL_MIE, OP_WRITE, 32'h0000A5F0, rd, rd5);
      xfer(SEL_MIE, OP_NONE, 0, rd, rd5);
      chk("mie_wr", rd, 32'h0000A5F0);
      xfer(SEL_MIE, OP_CLEAR, 32'h000000F0, rd, rd5);
      xfer(SEL_MIE, OP_NONE, 0, rd, rd5);
      chk("mie_clr", rd, 32'h0000A500);

      xfer(SEL_MODE, OP_WRITE, 32'h0000022A, rd, rd5);
      xfer(SEL_MIE, OP_WRITE, 32'h0000022E, rd, rd5);
      xfer(SEL_MODE, OP_NONE, 0, rd, rd5);
      chk("mode_rd", rd, 32'h0000022A);
      global_mie = 1'b1;

      // edge capture on channel 3
      @(negedge clk);
      irq_in[3] = 1'b1;
      @(negedge clk);
      irq_in[3] = 1'b0;
      @(negedge clk);
      chk("edge_early", 32'(pend_o), 0);
      @(negedge clk);
      chk("edge_pend", 32'(pend_o), 1);
      chk("edge_cause", 32'(cause), 3);
      xfer(SEL_MIP, OP_NONE, 0, rd, rd5);
      chk("edge_mip", rd, 32'h00000008);
      ack_pulse();
      chk("edge_ack", 32'(pend_o), 0);

      // priority 5 over 9
      irq_in[5] = 1'b1;
      irq_in[9] = 1'b1;
      @(negedge clk);
      irq_in[5] = 1'b0;
      irq_in[9] = 1'b0;
      repeat (2) @(negedge clk);
      chk("prio_first", 32'(cause), 5);
      ack_pulse();
      chk("prio_next", 32'(cause), 9);
      ack_pulse();
      chk("prio_done", 32'(pend_o), 0);

      // level channel 2
      irq_in[2] = 1'b1;
      repeat (3) @(negedge clk);
      chk("lvl_cause", 32'(cause), 2);
      xfer(SEL_MIP, OP_NONE, 0, rd, rd5);
      chk("lvl_mip", rd, 32'h00000004);
      ack_pulse();
      chk("lvl_ack", 32'(pend_o), 1);
      irq_in[2] = 1'b0;
      @(negedge clk);
      chk("lvl_drop1", 32'(pend_o), 1);
      @(negedge clk);
      chk("lvl_drop2", 32'(pend_o), 0);

      // CSR clear of edge pend without collision
      irq_in[1] = 1'b1;
      repeat (3) @(negedge clk);
      chk("clr_set", 32'(cause), 1);
      xfer(SEL_MIP, OP_CLEAR, 32'h00000002, rd, rd5);
      chk("clr_done", 32'(pend_o), 0);
      irq_in[1] = 1'b0;
      repeat (3) @(negedge clk);

      // edge set collides with CSR clear
      wait_cnt(3'd6);
      irq_in[1] = 1'b1;
      repeat (2) @(negedge clk);
      chk("coll_cnt", 32'(counter), 0);
      csr_sel   = SEL_MIP;
      csr_op    = OP_CLEAR;
      csr_wdata = 4'h2;
      @(negedge clk);
      csr_sel = SEL_NONE;
      csr_op  = OP_NONE;
      chk("coll_pend", 32'(pend_o), 1);
      chk("coll_cause", 32'(cause), 1);
      irq_in[1] = 1'b0;

      // narrow instance masking, fill all pend
      xfer(SEL_MIE, OP_WRITE, 32'hFFFFFFFF, rd, rd5);
      xfer(SEL_MIE, OP_NONE, 0, rd, rd5);
      chk("mie_all", rd, 32'h0000FFFF);
      chk("mie5_all", rd5, 32'h0000001F);
      xfer(SEL_MODE, OP_WRITE, 32'hFFFFFFFF, rd, rd5);
      xfer(SEL_MIP, OP_WRITE, 32'hFFFFFFFF, rd, rd5);
      xfer(SEL_MIP, OP_NONE, 0, rd, rd5);
      chk("mip_all", rd, 32'h0000FFFF);
      chk("mip5_all", rd5, 32'h0000001F);
      chk("all_cause", 32'(cause), 0);
      chk("all_pend", 32'(pend_o), 1);

      // async reset with everything pending
      #2 rst = 1'b1;
      #1;
      chk("ar_pend", 32'(pend_o), 0);
      chk("ar_cause", 32'(cause), 0);
      chk("ar_rdata", 32'(csr_rdata), 0);
      csr_sel = SEL_MIE;
      #1;
      chk("ar_mie", 32'(csr_rdata), 0);
      csr_sel = SEL_NONE;
      @(negedge clk);
      rst = 1'b0;

      // reset during a write leaves nothing behind
      wait_cnt(3'd0);
      csr_sel   = SEL_MIE;
      csr_op    = OP_WRITE;
      csr_wdata = 4'hF;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      csr_sel = SEL_NONE;
      csr_op  = OP_NONE;
      rst     = 1'b0;
      xfer(SEL_MIE, OP_NONE, 0, rd, rd5);
      chk("partial", rd, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
